// File: rtl/memory_pipe.sv
// memory_pipe: single-port memory with byte enables, post-reset init sweep,
// configurable read latency and out-of-range error reporting.
module memory_pipe #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH = 32,
  parameter int READ_LATENCY = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    wr,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic [DATA_WIDTH/8-1:0] byte_en,
  output logic                    ready,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    valid_out,
  output logic                    err
);
  if (READ_LATENCY < 1 || READ_LATENCY > 4 || DATA_WIDTH % 8 != 0 || DEPTH < 1 || DEPTH > 2**ADDR_WIDTH) begin : g_bad_param
    $error("memory_pipe: illegal parameter combination");
  end
  typedef enum logic {INIT, RUN} state_t;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] LAST = (ADDR_WIDTH+1)'(DEPTH - 1);
  state_t state, state_nx;
  logic [ADDR_WIDTH:0] cnt;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [READ_LATENCY-1:0] pv, pe;
  logic [DATA_WIDTH-1:0] pd [READ_LATENCY];
  logic werr, in_rng, rd_acc, wr_acc;
  assign ready = state == RUN;
  assign in_rng = {1'b0, addr} < DEPTH_C;
  assign rd_acc = en & ready & ~wr;
  assign wr_acc = en & ready & wr;
  assign valid_out = pv[READ_LATENCY-1];
  assign data_out = pd[READ_LATENCY-1];
  assign err = werr | pe[READ_LATENCY-1];
  always_comb state_nx = (state == INIT && cnt == LAST) ? RUN : state;
  // Stage data only advances with a valid read so the last stage holds the previous result.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= INIT;
      cnt <= '0;
      pv <= '0;
      pe <= '0;
      werr <= 1'b0;
      for (int i = 0; i < READ_LATENCY; i++) pd[i] <= '0;
    end else begin
      state <= state_nx;
      cnt <= state == INIT ? cnt + 1'b1 : '0;
      pv[0] <= rd_acc;
      pe[0] <= rd_acc & ~in_rng;
      if (rd_acc) pd[0] <= in_rng ? mem[addr] : '0;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pv[i] <= pv[i-1];
        pe[i] <= pe[i-1];
        if (pv[i-1]) pd[i] <= pd[i-1];
      end
      werr <= wr_acc & ~in_rng;
    end
  always_ff @(posedge clk)
    if (state == INIT) mem[cnt[ADDR_WIDTH-1:0]] <= INIT_VALUE;
    else if (wr_acc && in_rng)
      for (int b = 0; b < DATA_WIDTH/8; b++)
        if (byte_en[b]) mem[addr][8*b +: 8] <= data_in[8*b +: 8];
endmodule

// File: tb/tb_memory_pipe.sv
// tb_memory_pipe: randomized scoreboard bench for memory_pipe with an
// array-based reference model and a negedge monitor.
module tb_memory_pipe;
  localparam int AW = 5, DW = 32, DEPTH = 20, RL = 3;
  localparam logic [31:0] IV = 32'hA5A5_A5A5;
  logic clk = 0, rst = 1, en = 0, wr = 0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] data_in = '0;
  logic [DW/8-1:0] byte_en = '0;
  logic ready, valid_out, err;
  logic [DW-1:0] data_out;
  memory_pipe #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .READ_LATENCY(RL), .INIT_VALUE(IV)) dut (
    .clk(clk), .rst(rst), .en(en), .wr(wr), .addr(addr), .data_in(data_in),
    .byte_en(byte_en), .ready(ready), .data_out(data_out), .valid_out(valid_out), .err(err));
  always #5 clk = ~clk;
  typedef struct {int cyc; logic [31:0] data; logic err;} rd_t;
  rd_t rd_q[$];
  int wq[$];
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] last_d = '0;
  int cyc = 0, rel = 0, checks = 0, errors = 0;
  bit in_rst = 1;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask
  always @(negedge clk) begin
    logic ev, ee, er;
    logic [31:0] ed;
    ev = rd_q.size() > 0 && rd_q[0].cyc == cyc;
    ed = ev ? rd_q[0].data : last_d;
    ee = (ev && rd_q[0].err) || (wq.size() > 0 && wq[0] == cyc);
    er = !in_rst && (cyc - rel >= DEPTH);
    chk("valid_out", {31'b0, valid_out}, {31'b0, ev});
    chk("err", {31'b0, err}, {31'b0, ee});
    chk("ready", {31'b0, ready}, {31'b0, er});
    chk("data_out", data_out, ed);
    if (ev) begin
      last_d = ed;
      void'(rd_q.pop_front());
    end
    if (wq.size() > 0 && wq[0] == cyc) void'(wq.pop_front());
  end
  task automatic op(input bit e, input bit w, input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] be);
    rd_t r;
    int n;
    @(posedge clk); #2;
    en = e; wr = w; addr = a; data_in = d; byte_en = be;
    n = cyc + 1;
    if (e && ready) begin
      if (w) begin
        if (a < DEPTH) begin
          for (int b = 0; b < 4; b++) if (be[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
        end else wq.push_back(n);
      end else begin
        r.cyc = n + RL - 1;
        r.data = a < DEPTH ? ref_mem[a] : 32'h0;
        r.err = a >= DEPTH;
        rd_q.push_back(r);
      end
    end
  endtask
  task automatic do_reset(input int cycles);
    @(posedge clk); #2;
    rst = 1; en = 0; in_rst = 1; last_d = '0;
    rd_q.delete();
    wq.delete();
    repeat (cycles) @(posedge clk);
    #2;
    rst = 0; in_rst = 0; rel = cyc;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = IV;
  endtask
  task automatic idle(input int k);
    repeat (k) op(0, 0, '0, '0, '0);
  endtask
  initial begin
    do_reset(2);
    repeat (DEPTH + 3) op(1, 1, AW'($urandom), $urandom, 4'hF);
    idle(1);
    op(0, 0, 0, 0, 0); op(1, 0, 0, 0, 0); op(1, 0, 17, 0, 0); op(1, 0, 19, 0, 0);
    idle(RL + 1);
    op(1, 1, 5, 32'hDEAD_BEEF, 4'hF); idle(1); op(1, 0, 5, 0, 0); idle(RL + 1);
    op(1, 1, 9, 32'h1122_3344, 4'hF); op(1, 1, 9, 32'hAABB_CCDD, 4'b0101); op(1, 0, 9, 0, 0);
    op(1, 1, 9, 32'hFFFF_FFFF, 4'b0000); op(1, 0, 9, 0, 0); idle(RL + 1);
    op(1, 1, 25, 32'h1234_5678, 4'hF); idle(1); op(1, 0, 25, 0, 0); idle(RL + 1);
    op(1, 0, 1, 0, 0); op(1, 0, 2, 0, 0); op(1, 0, 3, 0, 0); op(1, 1, 2, 32'h0, 4'hF);
    op(1, 0, 2, 0, 0); idle(RL + 1);
    op(1, 1, 30, 0, 4'hF); op(1, 0, 31, 0, 0); idle(RL + 1);
    op(1, 0, 7, 0, 0);
    do_reset(1);
    idle(DEPTH + 4);
    for (int i = 0; i < 500; i++)
      op($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, AW'($urandom_range(0, 31)), $urandom, 4'($urandom));
    idle(RL + 3);
    chk("pending_reads", rd_q.size(), 0);
    chk("pending_errs", wq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/memory_pipe.md
Name: memory_pipe

Overview:
Parametrised single-port synchronous memory; next generation of the team's basic memory block. Adds per-byte write enables, a configurable read-latency pipeline, and a post-reset initialisation sweep in place of a whole-array asynchronous clear. Adds out-of-range address detection. Sits between a bus/agent-driven requester and storage. One request per cycle, with a ready qualifier.

Parameters:
ADDR_WIDTH, 5, address width in bits
DATA_WIDTH, 32, data width in bits; must be a multiple of 8
DEPTH, 32, number of words; 1 <= DEPTH <= 2**ADDR_WIDTH; need not be a power of 2
READ_LATENCY, 1, edges from read acceptance to data_out/valid_out update; legal range 1..4, other values fail elaboration
INIT_VALUE, 0, DATA_WIDTH-bit value written to every word during the INIT sweep

Ports:
clk  input  1  clock; all state updates on posedge
rst  input  1  asynchronous, active-high reset
en  input  1  request strobe
wr  input  1  1 = write, 0 = read; sampled with en
addr  input  ADDR_WIDTH  word address
data_in  input  DATA_WIDTH  write data
byte_en  input  DATA_WIDTH/8  write lane enables; bit b covers data_in[8b+7:8b]
ready  output  1  block accepts requests this cycle
data_out  output  DATA_WIDTH  read data
valid_out  output  1  one-cycle pulse per completed read
err  output  1  one-cycle pulse for an out-of-range access

Behaviour:
- Reset (rst=1, asynchronous): state=INIT, init counter=0, ready=0, data_out=0, valid_out=0, err=0, all read-pipeline stages invalid. Array contents are not touched by reset.
- FSM states: INIT, RUN.
- INIT: first posedge with rst=0 writes INIT_VALUE to address 0. Each following edge writes the next address. The edge writing DEPTH-1 moves state to RUN and sets ready=1, so ready is high after edge DEPTH. Sweep takes exactly DEPTH cycles.
- In INIT, en/wr/addr/data are ignored: no write, no read, no err.
- Accepted request: en=1 && ready=1 at a posedge. ready is registered and stays 1 in RUN. There is no back-pressure in RUN.
- Write (wr=1, addr<DEPTH): for each b with byte_en[b]=1, MEM[addr][8b+7:8b] <= data_in[8b+7:8b]; other lanes keep their values. byte_en=0 is a legal no-op with no err. Writes never assert valid_out.
- Read (wr=0, addr<DEPTH), accepted at edge N: data_out <= MEM[addr] and valid_out=1 after edge N+READ_LATENCY-1. valid_out lasts exactly one cycle.
- The read samples the array at edge N. A write accepted at edge N+1 to the same address does not affect that read's data, even if it is still in flight.
- Back-to-back reads: throughput of one per cycle, responses in order. Writes may be interleaved freely with in-flight reads.
- data_out holds the last read data while valid_out=0.
- Out of range (addr >= DEPTH):
  - Write: dropped; err=1 for the cycle after edge N.
  - Read: completes normally with data_out=0 and valid_out=1; err=1 in the same cycle as that valid_out.
  - If a write's err and a read's err fall in the same cycle, err is a single high cycle (logical OR).
- Reset mid-operation (INIT or RUN, any cycle): all in-flight reads discarded, no valid_out produced. Outputs return to reset values immediately. The INIT sweep restarts from address 0 after rst deasserts.
- Address width rule: addr compared unsigned against DEPTH. The init counter is ADDR_WIDTH+1 bits so DEPTH=2**ADDR_WIDTH terminates correctly.

Test Plan:
- Reset, then hold en=1 wr=1 during INIT, INIT_VALUE=32'hA5A5_A5A5, DEPTH=32 -> ready=0 for edges 1..31, ready=1 after edge 32. Reads of addr 0, 17 and 31 return 32'hA5A5_A5A5, confirming the INIT-time writes were ignored.
- READ_LATENCY=3: write 32'hDEAD_BEEF to addr 5, then read addr 5 at edge N -> valid_out=1 and data_out=32'hDEAD_BEEF only after edge N+2. valid_out is low the cycle before and the cycle after.
- Byte lanes: addr 9 holds 32'h1122_3344; write data_in=32'hAABB_CCDD with byte_en=4'b0101 -> read returns 32'h11BB_33DD. A byte_en=4'b0000 write leaves it unchanged with no err.
- DEPTH=20, ADDR_WIDTH=5: write to addr 25 -> err pulse after the write edge, no array change. Read addr 25 -> valid_out=1, data_out=0, err=1 in the same cycle.
- READ_LATENCY=2: reads of addr 1,2,3 on three consecutive edges, with a write of 32'h0 to addr 2 on the next edge -> three consecutive valid_out pulses in order, carrying the original contents of 1,2,3.
- Assert rst one cycle after a read is accepted (READ_LATENCY=4) -> no valid_out ever appears for that read. ready=0 immediately, then a full 32-cycle INIT before ready=1.
